// File: rtl/mips_rf_pkg.sv
// Shared types and constants for the multi-port MIPS register file.
// The optional same-cycle write-to-read bypass is selected by REGFILE_BYPASS_EN.
package mips_rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS      = 1 << ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/mips_regfile_mp_if.sv
// Bus interface of the register file: read ports, two writeback ports,
// issue/flush controls for the in-flight-write scoreboard and the pending count.
// Option macro affecting the attached file: REGFILE_BYPASS_EN.
//
// Control semantics: WE0/WE1, ISSUE and FLUSH are single-cycle strobes sampled
// on the rising clock edge; there is no ready/back-pressure, every strobe seen
// at an edge takes effect at that edge. Read outputs are combinational.
interface mips_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] RA;
    logic [NUM_RD*DATA_W-1:0] RD;
    logic [NUM_RD-1:0]        RD_PEND;
    logic                     WE0;
    logic [ADDR_W-1:0]        WA0;
    logic [DATA_W-1:0]        WD0;
    logic                     WE1;
    logic [ADDR_W-1:0]        WA1;
    logic [DATA_W-1:0]        WD1;
    logic                     ISSUE;
    logic [ADDR_W-1:0]        IA;
    logic                     FLUSH;
    logic [ADDR_W:0]          PEND_CNT;

    modport master (
        output RA, WE0, WA0, WD0, WE1, WA1, WD1, ISSUE, IA, FLUSH,
        input  RD, RD_PEND, PEND_CNT
    );

    modport slave (
        input  RA, WE0, WA0, WD0, WE1, WA1, WD1, ISSUE, IA, FLUSH,
        output RD, RD_PEND, PEND_CNT
    );
endinterface

// File: rtl/mips_rf_scoreboard.sv
// In-flight-write scoreboard: one pending bit per register plus a registered
// count of pending registers maintained incrementally.
// Priority per register: flush > set > clear.
module mips_rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   set_en,     // already qualified issue (no r0, no flush)
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr0_en,    // qualified write on port 0
    input  logic [ADDR_W-1:0]      clr0_addr,
    input  logic                   clr1_en,    // qualified write on port 1
    input  logic [ADDR_W-1:0]      clr1_addr,
    input  logic                   flush,
    output logic [(1<<ADDR_W)-1:0] pend,
    output logic [ADDR_W:0]        pend_cnt
);
    import mips_rf_pkg::*;

    logic [(1<<ADDR_W)-1:0] pend_nxt;
    logic                   inc;
    logic                   dec0;
    logic                   dec1;

    // Next pending vector and counter deltas; a set on the same address as a clear survives.
    always_comb begin
        pend_nxt = pend;
        if (clr0_en) pend_nxt[clr0_addr] = 1'b0;
        if (clr1_en) pend_nxt[clr1_addr] = 1'b0;
        if (set_en)  pend_nxt[set_addr]  = 1'b1;

        inc  = set_en && !pend[set_addr];
        dec0 = clr0_en && pend[clr0_addr] && !(set_en && set_addr == clr0_addr);
        // Both ports retiring the same register count as one clear.
        dec1 = clr1_en && pend[clr1_addr] && !(set_en && set_addr == clr1_addr)
               && !(clr0_en && clr0_addr == clr1_addr);
    end

    // Pending state and counter; flush discards everything.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else if (flush) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec0) - (ADDR_W+1)'(dec1);
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port GPR file for the pipelined MIPS core: NUM_RD combinational read
// ports, two writeback ports (port 1 wins on address collision), optional
// hardwired zero register and an in-flight-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic              CLK,
    input logic              RESET,
    mips_regfile_mp_if.slave bus
);
    import mips_rf_pkg::*;

    localparam int NREGS_P = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]  mem [NREGS_P];
    logic [NREGS_P-1:0] pend;
    logic               wr0;
    logic               wr1;
    logic               iss_ok;
    logic [ADDR_W-1:0]  ra_v [NUM_RD];

    // r0 is invisible to writes and issues when it is hardwired to zero.
    assign wr0    = bus.WE0 && (ZERO_REG == 0 || bus.WA0 != ZADDR);
    assign wr1    = bus.WE1 && (ZERO_REG == 0 || bus.WA1 != ZADDR);
    assign iss_ok = bus.ISSUE && !bus.FLUSH && (ZERO_REG == 0 || bus.IA != ZADDR);

    // Storage array; port 1 is written last so it wins a same-address collision.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREGS_P; i++) mem[i] <= '0;
        end else begin
            if (wr0) mem[bus.WA0] <= bus.WD0;
            if (wr1) mem[bus.WA1] <= bus.WD1;
        end
    end

    mips_rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .CLK       (CLK),
        .RESET     (RESET),
        .set_en    (iss_ok),
        .set_addr  (bus.IA),
        .clr0_en   (wr0),
        .clr0_addr (bus.WA0),
        .clr1_en   (wr1),
        .clr1_addr (bus.WA1),
        .flush     (bus.FLUSH),
        .pend      (pend),
        .pend_cnt  (bus.PEND_CNT)
    );

    // Read muxes: stored state, optionally overridden by same-cycle writes, r0 forced to zero.
    always_comb begin
        bus.RD      = '0;
        bus.RD_PEND = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra_v[p] = bus.RA[p*ADDR_W +: ADDR_W];
            bus.RD[p*DATA_W +: DATA_W] = mem[ra_v[p]];
            bus.RD_PEND[p]             = pend[ra_v[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr1 && bus.WA1 == ra_v[p]) begin
                bus.RD[p*DATA_W +: DATA_W] = bus.WD1;
            end else if (wr0 && bus.WA0 == ra_v[p]) begin
                bus.RD[p*DATA_W +: DATA_W] = bus.WD0;
            end
            if (((wr0 && bus.WA0 == ra_v[p]) || (wr1 && bus.WA1 == ra_v[p]))
                && !(iss_ok && bus.IA == ra_v[p])) begin
                bus.RD_PEND[p] = 1'b0;
            end
`endif
            if (ZERO_REG != 0 && ra_v[p] == ZADDR) begin
                bus.RD[p*DATA_W +: DATA_W] = '0;
                bus.RD_PEND[p]             = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench for mips_regfile_mp (default parameters, two read ports).
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_mips_regfile_mp;
    import mips_rf_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_errors;
    logic [DATA_W-1:0] exp_q [$];

    mips_regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    mips_regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.WE0 = 1'b0; bus.WA0 = '0; bus.WD0 = '0;
        bus.WE1 = 1'b0; bus.WA1 = '0; bus.WD1 = '0;
        bus.ISSUE = 1'b0; bus.IA = '0; bus.FLUSH = 1'b0;
    endtask

    task automatic set_ra(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        bus.RA = {a1, a0};
    endtask

    task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.WE0 = 1'b1; bus.WA0 = a; bus.WD0 = d;
    endtask

    task automatic wr1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.WE1 = 1'b1; bus.WA1 = a; bus.WD1 = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        bus.ISSUE = 1'b1; bus.IA = a;
    endtask

    // Clock the currently driven inputs in, then drop the strobes and let reads settle.
    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rd0();
        return bus.RD[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rd1();
        return bus.RD[2*DATA_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] cnt();
        return DATA_W'(bus.PEND_CNT);
    endfunction

    logic [DATA_W-1:0] vals [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        vals[0] = 32'h0102_0304; vals[1] = 32'hA5A5_5A5A;
        vals[2] = 32'h0000_0001; vals[3] = 32'hFFFF_FFFE;

        // Reset state
        RESET = 1'b1;
        idle();
        set_ra(5'd5, 5'd31);
        #3;
        check("reset_rd0", rd0(), 32'h0);
        check("reset_rd1", rd1(), 32'h0);
        check("reset_pend", DATA_W'(bus.RD_PEND), 32'h0);
        check("reset_cnt", cnt(), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // 1: write r5 and issue it, then asynchronous reset mid-cycle
        wr0(5'd5, 32'hDEAD_BEEF); issue(5'd5);
        tick();
        check("t1_rd_r5", rd0(), 32'hDEAD_BEEF);
        check("t1_cnt_before", cnt(), 32'h1);
        check("t1_pend_r5", DATA_W'(bus.RD_PEND[0]), 32'h1);
        #2 RESET = 1'b1;
        #1;
        check("t1_rd_after_rst", rd0(), 32'h0);
        check("t1_cnt_after_rst", cnt(), 32'h0);
        check("t1_pend_after_rst", DATA_W'(bus.RD_PEND[0]), 32'h0);
        #1 RESET = 1'b0;
        @(posedge CLK); #1;

        // 2: both ports hit r7, port 1 wins
        wr0(5'd7, 32'h11); wr1(5'd7, 32'h22);
        tick();
        set_ra(5'd7, 5'd7);
        #1;
        check("t2_collide_p0", rd0(), 32'h22);
        check("t2_collide_p1", rd1(), 32'h22);

        // 3: r0 ignores writes and issues
        wr0(5'd0, 32'hFFFF_FFFF); issue(5'd0);
        tick();
        set_ra(5'd0, 5'd0);
        #1;
        check("t3_r0_read", rd0(), 32'h0);
        check("t3_r0_cnt", cnt(), 32'h0);

        // 4: re-issue of a retiring register keeps it pending
        issue(5'd3);
        tick();
        set_ra(5'd3, 5'd0);
        #1;
        check("t4_cnt_issue", cnt(), 32'h1);
        wr1(5'd3, 32'h33); issue(5'd3);
        tick();
        check("t4_pend_kept", DATA_W'(bus.RD_PEND[0]), 32'h1);
        check("t4_cnt_kept", cnt(), 32'h1);
        check("t4_data", rd0(), 32'h33);
        wr0(5'd3, 32'h34);
        tick();
        check("t4_pend_clr", DATA_W'(bus.RD_PEND[0]), 32'h0);
        check("t4_cnt_clr", cnt(), 32'h0);

        // 5: three issues, then flush with a concurrent issue and write
        issue(5'd1); tick();
        issue(5'd2); tick();
        issue(5'd3); tick();
        check("t5_cnt3", cnt(), 32'h3);
        bus.FLUSH = 1'b1; issue(5'd4); wr0(5'd2, 32'hAB);
        tick();
        set_ra(5'd4, 5'd2);
        #1;
        check("t5_cnt_flush", cnt(), 32'h0);
        check("t5_pend4", DATA_W'(bus.RD_PEND[0]), 32'h0);
        check("t5_pend2", DATA_W'(bus.RD_PEND[1]), 32'h0);
        check("t5_write_commit", rd1(), 32'hAB);

        // Two distinct clears in one cycle
        issue(5'd10); tick();
        issue(5'd11); tick();
        check("dual_cnt2", cnt(), 32'h2);
        wr0(5'd10, 32'h10); wr1(5'd11, 32'h11);
        tick();
        check("dual_cnt0", cnt(), 32'h0);

        // Both ports clearing the same register count once
        issue(5'd12); tick();
        issue(5'd14); tick();
        wr0(5'd12, 32'h1); wr1(5'd12, 32'h2);
        tick();
        check("dup_clear_cnt", cnt(), 32'h1);
        wr0(5'd14, 32'h4);
        tick();

        // Write to a non-pending register leaves it non-pending
        wr1(5'd13, 32'h1313);
        tick();
        set_ra(5'd13, 5'd12);
        #1;
        check("nonpend_cnt", cnt(), 32'h0);
        check("nonpend_pend", DATA_W'(bus.RD_PEND[0]), 32'h0);
        check("nonpend_data", rd0(), 32'h1313);
        check("dup_data", rd1(), 32'h2);

        // Fill r20..r23 alternating ports, then read back in order
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) wr0(ADDR_W'(20 + i), vals[i]);
            else            wr1(ADDR_W'(20 + i), vals[i]);
            exp_q.push_back(vals[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_ra(5'd0, ADDR_W'(20 + i));
            #1;
            check($sformatf("fill_r%0d", 20 + i), rd1(), exp_q.pop_front());
        end

        // 6: same-cycle read of a register being written
        wr0(5'd9, 32'h77); issue(5'd9);
        tick();
        set_ra(5'd9, 5'd9);
        wr0(5'd9, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t6_same_cycle", rd0(), 32'h55);
        check("t6_same_pend", DATA_W'(bus.RD_PEND[0]), 32'h0);
`else
        check("t6_same_cycle", rd0(), 32'h77);
        check("t6_same_pend", DATA_W'(bus.RD_PEND[0]), 32'h1);
`endif
        tick();
        check("t6_next_cycle", rd0(), 32'h55);
        check("t6_next_pend", DATA_W'(bus.RD_PEND[0]), 32'h0);
        check("t6_cnt", cnt(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
